// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Key-event handshake between the PS/2 key decoder and the scan-code-to-ASCII
//   stage.
//   key_valid : head event present
//   key_scan  : scan code of the head event
//   key_case  : 1 = upper case / shifted
//   key_ready : consumer accepts the head event when key_valid is also high
interface ps2_key_decoder_if;
  logic       key_valid;
  logic [7:0] key_scan;
  logic       key_case;
  logic       key_ready;

  modport master (output key_valid, output key_scan, output key_case, input key_ready);
  modport slave  (input key_valid, input key_scan, input key_case, output key_ready);
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the raw PS/2 byte stream into buffered key-press events
//   {letter case, scan code}. Break, extended and Pause sequences, Shift and
//   Caps Lock are consumed here; only plain make codes are queued.
// Ports
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_rx_done_tick     : one-cycle strobe, i_rx_data valid
//   i_rx_data          : received byte
//   key_if (master)    : key_valid/key_scan/key_case out, key_ready in
//   o_caps_led         : current Caps Lock state
//   o_overflow         : sticky, an event was dropped on a full FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_rx_done_tick,
  input  logic [7:0]                i_rx_data,
  ps2_key_decoder_if.master         key_if,
  output logic                      o_caps_led,
  output logic                      o_overflow
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BRK     = 3'd1;
  localparam logic [2:0] ST_EXT     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_skip;
  logic          r_lshift, r_rshift, r_caps;
  logic          r_overflow;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;

  logic w_make, w_letter, w_case, w_push, w_pop, w_push_ok;

  // Bytes that never become events when seen in IDLE: prefixes, keyboard
  // replies, modifiers and Alt/Ctrl.
  always_comb begin
    w_make = 1'b1;
    case (i_rx_data)
      8'hF0, 8'hE0, 8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF,
      8'h12, 8'h59, 8'h58, 8'h11, 8'h14: w_make = 1'b0;
      default:                           w_make = 1'b1;
    endcase
  end

  always_comb begin
    w_letter = 1'b0;
    case (i_rx_data)
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A: w_letter = 1'b1;
      default:                                                w_letter = 1'b0;
    endcase
  end

  // Caps only flips letters, so Shift+Caps yields lower-case letters.
  assign w_case    = (r_lshift | r_rshift) ^ (r_caps & w_letter);
  assign w_push    = i_rx_done_tick && (r_state == ST_IDLE) && w_make;
  assign w_pop     = (r_count != '0) && key_if.key_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = w_push && ((r_count < DEPTH_C) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_skip     <= '0;
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_caps     <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_rx_done_tick) begin
        case (r_state)
          ST_IDLE: begin
            case (i_rx_data)
              8'hF0: r_state <= ST_BRK;
              8'hE0: r_state <= ST_EXT;
              8'hE1: begin r_state <= ST_PAUSE; r_skip <= 3'd7; end
              8'h12: r_lshift <= 1'b1;
              8'h59: r_rshift <= 1'b1;
              8'h58: r_caps   <= ~r_caps;
              default: ;
            endcase
          end
          ST_BRK: begin
            if (i_rx_data == 8'h12) r_lshift <= 1'b0;
            if (i_rx_data == 8'h59) r_rshift <= 1'b0;
            r_state <= ST_IDLE;
          end
          ST_EXT:     r_state <= (i_rx_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
          ST_EXT_BRK: r_state <= ST_IDLE;
          ST_PAUSE: begin
            r_skip <= r_skip - 3'd1;
            if (r_skip == 3'd1) r_state <= ST_IDLE;
          end
          default:    r_state <= ST_IDLE;
        endcase
      end

      if (w_push_ok) begin
        r_mem[r_tail] <= {w_case, i_rx_data};
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;

      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign key_if.key_valid = (r_count != '0);
  assign key_if.key_scan  = r_mem[r_head][7:0];
  assign key_if.key_case  = r_mem[r_head][8];
  assign o_caps_led       = r_caps;
  assign o_overflow       = r_overflow;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed and randomized byte streams into ps2_key_decoder. A reference
//   model tracks prefix/modifier state and FIFO occupancy, queueing expected
//   events; a negedge monitor compares the DUT head on every handshake.
module tb_ps2_key_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx_tick;
  logic [7:0] rx_data;
  logic       caps_led, overflow;

  ps2_key_decoder_if kif();

  ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_rx_done_tick(rx_tick),
    .i_rx_data     (rx_data),
    .key_if        (kif),
    .o_caps_led    (caps_led),
    .o_overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] scan; logic kcase; } ev_t;

  ev_t  exp_q[$];
  int   m_count;
  int   m_skip;
  bit   m_lsh, m_rsh, m_caps, m_ovf, m_e0, m_f0;
  bit   letter_tab [256];
  logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                               8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                               8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level keyboard protocol: returns 1 if the byte is a make code.
  function automatic bit model_byte(input logic [7:0] b);
    if (m_skip > 0) begin m_skip--; return 0; end
    if (m_e0) begin
      if (m_f0)          begin m_e0 = 0; m_f0 = 0; end
      else if (b == 8'hF0) m_f0 = 1;
      else               m_e0 = 0;
      return 0;
    end
    if (m_f0) begin
      if (b == 8'h12) m_lsh = 0;
      if (b == 8'h59) m_rsh = 0;
      m_f0 = 0;
      return 0;
    end
    case (b)
      8'hF0: m_f0 = 1;
      8'hE0: m_e0 = 1;
      8'hE1: m_skip = 7;
      8'h12: m_lsh = 1;
      8'h59: m_rsh = 1;
      8'h58: m_caps = !m_caps;
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'h11, 8'h14: ;
      default: return 1;
    endcase
    return 0;
  endfunction

  // Applies the inputs seen at this clock edge to the model.
  task automatic model_edge();
    bit  pop;
    ev_t e;
    if (reset) begin
      exp_q.delete();
      m_count = 0; m_skip = 0;
      m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0; m_e0 = 0; m_f0 = 0;
    end else begin
      pop = kif.key_ready && (m_count > 0);
      if (rx_tick) begin
        e.scan  = rx_data;
        e.kcase = (m_lsh | m_rsh) ^ (m_caps & letter_tab[rx_data]);
        if (model_byte(rx_data)) begin
          if (m_count < 4 || pop) begin exp_q.push_back(e); m_count++; end
          else m_ovf = 1;
        end
      end
      if (pop) m_count--;
    end
  endtask

  task automatic step(input bit t, input logic [7:0] d, input bit rdy, input bit rst);
    rx_tick = t; rx_data = d; kif.key_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    rx_tick = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [], input bit rdy);
    foreach (s[i]) step(1'b1, s[i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("key_valid", kif.key_valid, exp_q.size() != 0);
      chk("caps_led", caps_led, m_caps);
      chk("overflow", overflow, m_ovf);
      if (kif.key_valid && exp_q.size() != 0) begin
        chk("key_scan", kif.key_scan, exp_q[0].scan);
        chk("key_case", kif.key_case, exp_q[0].kcase);
        if (kif.key_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] seq [];
    int r;
    logic [7:0] b;
    foreach (letters[i]) letter_tab[letters[i]] = 1'b1;
    rx_tick = 0; rx_data = 0; kif.key_ready = 0; reset = 1;
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_scan", kif.key_scan, 0);
    chk("rst_case", kif.key_case, 0);
    chk("rst_caps", caps_led, 0);
    chk("rst_ovf", overflow, 0);
    mon_en = 1;

    // press/release 'a'
    seq = '{8'h1C, 8'hF0, 8'h1C}; send_seq(seq, 1); idle(3, 1);
    // shift
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C}; send_seq(seq, 1); idle(3, 1);
    // caps, then right shift with caps on, then restore
    seq = '{8'h58, 8'hF0, 8'h58, 8'h1C, 8'h16}; send_seq(seq, 1);
    chk("caps_on", caps_led, 1);
    seq = '{8'h59, 8'h1C, 8'hF0, 8'h59, 8'h58}; send_seq(seq, 1); idle(3, 1);
    // extended / pause filtering
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12,
            8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h24};
    send_seq(seq, 1); idle(3, 1);
    // backpressure with overflow
    seq = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C}; send_seq(seq, 0);
    chk("ovf_set", overflow, 1);
    idle(6, 1);
    step(0, 8'h00, 0, 1);
    // full plus simultaneous pop
    seq = '{8'h15, 8'h1D, 8'h24, 8'h2D}; send_seq(seq, 0);
    step(1, 8'h2C, 1, 0);
    chk("full_pop_ovf", overflow, 0);
    idle(6, 1);
    // reset mid-break
    step(1, 8'hF0, 1, 0);
    step(0, 8'h00, 0, 1);
    chk("rst2_valid", kif.key_valid, 0);
    chk("rst2_caps", caps_led, 0);
    step(1, 8'h1C, 1, 0);
    idle(3, 1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 700 == 699) begin step(0, 8'h00, 0, 1); continue; end
      r = $urandom_range(0, 99);
      if      (r < 45) b = letters[$urandom_range(0, 25)];
      else if (r < 55) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r < 62) b = 8'hF0;
      else if (r < 67) b = 8'h58;
      else if (r < 72) b = 8'hE0;
      else if (r < 75) b = 8'hE1;
      else             b = 8'($urandom_range(0, 255));
      step($urandom_range(0, 1), b, $urandom_range(0, 9) < 6, 0);
    end
    idle(10, 1);
    chk("drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
